uart_word_rx: RTL and testbench

UART receiver that sits directly upstream of the UART FIFO. It deserialises 8N1 bytes from the rx pin, assembles WIDTH/8 bytes little-endian into one word, and pulses a one-cycle write with the word on word_out. The outputs connect directly to the FIFO's write/data_in. Single clock domain (clk); partial words are discarded on framing error or inter-byte timeout.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_word_rx_if.sv | 10 +
 rtl/uart_rx_byte.sv | 84 ++++++++
 rtl/uart_word_rx.sv | 67 ++++++
 tb/tb_uart_word_rx.sv | 129 ++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and constants.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 868;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
endpackage

// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if: serial input and word-write outputs of the word receiver.
interface uart_word_rx_if #(parameter int WIDTH = 32);
  logic rx;
  logic write;
  logic [WIDTH-1:0] word_out;
  logic frame_err;
  logic timeout;
  modport master (input rx, output write, word_out, frame_err, timeout);
  modport slave (output rx, input write, word_out, frame_err, timeout);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: synchronised 8N1 byte deserialiser with start-glitch and break handling.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       idle,
  output logic       start
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sh, sh_n;
  logic rx_m, rx_s, tick, tick_half;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign tick_half = cnt == CW'(HALF - 1);
  assign data = sh;
  assign idle = state == IDLE;
  assign start = idle && !rx_s;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end
  // Byte outputs are combinational so the word stage can register the result on the stop-sample edge.
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_n = bit_idx;
    sh_n = sh;
    byte_valid = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
          bit_n = '0;
        end
      end
      START: if (tick_half) begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n = '0;
        sh_n = {rx_s, sh[7:1]};
        bit_n = bit_idx + 1'b1;
        if (bit_idx == 3'(UART_DATA_BITS - 1)) state_n = STOP;
      end
      STOP: if (tick) begin
        cnt_n = '0;
        byte_valid = rx_s;
        frame_err = !rx_s;
        state_n = rx_s ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: packs received UART bytes little-endian into words with inter-byte timeout.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_CLKS = 16 * CLKS_PER_BIT
) (
  input logic clk,
  input logic reset,
  uart_word_rx_if.master bus
);
  localparam int NB = WIDTH / UART_DATA_BITS;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic b_valid, b_ferr, idle, start, last, armed, tmo_hit;
  logic [7:0] b_data;
  logic [IW-1:0] idx;
  logic [TW-1:0] icnt;
  logic [WIDTH-1:0] shadow, full, word_q;
  logic write_q, ferr_q, tmo_q;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk),
    .reset(reset),
    .rx(bus.rx),
    .byte_valid(b_valid),
    .data(b_data),
    .frame_err(b_ferr),
    .idle(idle),
    .start(start)
  );
  assign last = idx == IW'(NB - 1);
  assign armed = idx != '0 && idle;
  assign tmo_hit = armed && icnt == TW'(TIMEOUT_CLKS - 1);
  assign bus.write = write_q;
  assign bus.word_out = word_q;
  assign bus.frame_err = ferr_q;
  assign bus.timeout = tmo_q;
  always_comb begin
    full = shadow;
    full[UART_DATA_BITS*idx +: UART_DATA_BITS] = b_data;
  end
  // A timeout coinciding with a start bit still fires; the new byte then lands as byte 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      ferr_q <= 1'b0;
      tmo_q <= 1'b0;
      word_q <= '0;
      shadow <= '0;
      idx <= '0;
      icnt <= '0;
    end else begin
      write_q <= b_valid && last;
      ferr_q <= b_ferr;
      tmo_q <= tmo_hit;
      icnt <= (armed && !tmo_hit && !start) ? icnt + 1'b1 : '0;
      if (b_valid) begin
        shadow <= full;
        idx <= last ? '0 : idx + 1'b1;
        if (last) word_q <= full;
      end else if (b_ferr || tmo_hit) begin
        idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: directed scoreboard bench for the UART word receiver.
module tb_uart_word_rx;
  localparam int W = 32;
  localparam int CPB = 16;
  localparam int TMO = 200;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, passes = 0, writes = 0, exp_writes = 0, ferrs = 0, tmos = 0;
  longint cyc = 0;
  longint wr_cyc[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] last_word;
  int t0, w0;
  uart_word_rx_if #(.WIDTH(W)) bus ();
  uart_word_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_err) ferrs++;
      if (bus.timeout) tmos++;
      if (bus.write || bus.frame_err || bus.timeout)
        check("pulse_onehot", 64'(bus.write + bus.frame_err + bus.timeout), 64'd1);
      if (bus.write) begin
        writes++;
        wr_cyc.push_back(cyc);
        if (sb.size() == 0) check("write_expected", 64'(sb.size()), 64'd1);
        else check("word_out", bus.word_out, sb.pop_front());
      end
    end
  end
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1, input int idle = CPB);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (idle) @(negedge clk);
  endtask
  task automatic send_word(input logic [W-1:0] w, input int idle = CPB);
    sb.push_back(w);
    exp_writes++;
    for (int k = 0; k < W / 8; k++) send_byte(w[8*k +: 8], 1'b1, idle);
  endtask
  initial begin
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_write", bus.write, 0);
    check("rst_word_out", bus.word_out, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_timeout", bus.timeout, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_word(32'h12345678);
    repeat (40) @(negedge clk);
    check("t1_writes", writes, 1);
    check("t1_word_hold", bus.word_out, 32'h12345678);
    check("t1_no_err", ferrs + tmos, 0);
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_write", writes, 1);
    check("glitch_no_ferr", ferrs, 0);
    send_word(32'h87654321);
    repeat (40) @(negedge clk);
    check("glitch_next_word", writes, 2);
    last_word = 32'h87654321;
    send_byte(8'hAA);
    check("partial_hidden", bus.word_out, last_word);
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_count", ferrs, 1);
    send_word(32'h04030201);
    repeat (40) @(negedge clk);
    check("ferr_then_word", writes, 3);
    t0 = tmos;
    send_byte(8'h11);
    send_byte(8'h22, 1'b1, 150);
    check("tmo_not_yet", tmos, t0);
    repeat (100) @(negedge clk);
    check("tmo_fired", tmos, t0 + 1);
    check("tmo_word_hold", bus.word_out, 32'h04030201);
    send_word(32'hAABBCCDD);
    repeat (40) @(negedge clk);
    check("tmo_then_word", writes, 4);
    send_word(32'h04030201, 0);
    send_word(32'h08070605, 0);
    repeat (40) @(negedge clk);
    check("b2b_writes", writes, 6);
    check("b2b_spacing", 64'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2]), 64'd640);
    w0 = writes;
    send_byte(8'h10);
    send_byte(8'h20);
    bus.rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    reset = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    check("mid_rst_write", bus.write, 0);
    check("mid_rst_word_out", bus.word_out, 0);
    check("mid_rst_ferr", bus.frame_err, 0);
    check("mid_rst_tmo", bus.timeout, 0);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    check("mid_rst_no_write", writes, w0);
    send_word(32'hCAFEF00D);
    repeat (50) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("total_writes", writes, exp_writes);
    check("total_ferr", ferrs, 1);
    check("total_tmo", tmos, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
